dmem_ctrl: RTL and testbench

- Responder-side data-memory controller behind the EX stage. It consumes the memory request EX produces: MemRead/MemWrite, func3, the ALU result as address, and rs2 data as store data.
- Drives a valid/ready word-wide memory port, performs byte-lane alignment and load extension, and stalls the pipeline until the access completes.
- Sits between the EX/MEM pipeline register and the data memory.

---
 rtl/dmem_pkg.sv | 42 ++++
 rtl/dmem_lane_align.sv | 63 ++++++
 rtl/dmem_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and constants for the data-memory controller.
//               Holds the controller state encoding, the access-size codes,
//               the RV32I load/store func3 codes and the size-decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Access size, taken from func3[1:0]; func3[1] set means word.
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    function automatic logic [1:0] f3_size(input logic [2:0] f3);
        if (f3[1])
            return SZ_W;
        else if (f3[0])
            return SZ_H;
        else
            return SZ_B;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : dmem_lane_align
// Description : Purely combinational byte-lane logic.
//               Store side: replicates the store operand across all lanes and
//               builds the byte-enable mask from size and byte offset.
//               Load side: shifts the returned word down by the byte offset
//               and sign- or zero-extends according to func3.
// Ports       : i_st_size/i_st_off/i_st_data -> o_st_wdata/o_st_mask
//               i_ld_func3/i_ld_off/i_ld_word -> o_ld_data
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  i_st_size,
    input  logic [1:0]  i_st_off,
    input  logic [31:0] i_st_data,
    output logic [31:0] o_st_wdata,
    output logic [3:0]  o_st_mask,
    input  logic [2:0]  i_ld_func3,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_ld_word,
    output logic [31:0] o_ld_data
);

    logic [31:0] w_shifted;

    // Store formatting: the memory picks the right lane via the mask, so
    // the operand is simply replicated into every lane.
    always_comb begin
        o_st_wdata = i_st_data;
        o_st_mask  = 4'b1111;
        case (i_st_size)
            SZ_B: begin
                o_st_wdata = {4{i_st_data[7:0]}};
                o_st_mask  = 4'b0001 << i_st_off;
            end
            SZ_H: begin
                o_st_wdata = {2{i_st_data[15:0]}};
                o_st_mask  = 4'b0011 << {i_st_off[1], 1'b0};
            end
            default: begin
                o_st_wdata = i_st_data;
                o_st_mask  = 4'b1111;
            end
        endcase
    end

    // Load extraction: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        w_shifted = i_ld_word >> {i_ld_off, 3'b000};
        case (i_ld_func3)
            F3_LB:   o_ld_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_LH:   o_ld_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_LBU:  o_ld_data = {24'h000000, w_shifted[7:0]};
            F3_LHU:  o_ld_data = {16'h0000, w_shifted[15:0]};
            default: o_ld_data = w_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ctrl
// Description : Responder-side data-memory controller for the MEM stage.
//               Accepts a load or store from EX/MEM, drives a word-wide
//               valid/ready memory port with lane-aligned data and mask,
//               extends load data, and stalls the pipeline until done.
// Ports       : i_clk, i_rst_n (sync, active low)
//               pipeline side : i_req_valid, i_mem_read, i_mem_write,
//                               i_func3, i_addr, i_wdata -> o_stall, o_rdata,
//                               o_rdata_valid, o_misaligned
//               memory side   : o_mem_req, o_mem_wen, o_mem_addr,
//                               o_mem_wdata, o_mem_mask <- i_mem_ready,
//                               i_mem_rvalid, i_mem_rdata
// Config      : DMEM_MISALIGN_TRAP_EN - when defined, misaligned requests
//               pulse o_misaligned and are dropped; otherwise they are
//               force-aligned and executed, and o_misaligned is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [2:0]        i_func3,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_stall,
    output logic [31:0]       o_rdata,
    output logic              o_rdata_valid,
    output logic              o_misaligned,
    output logic              o_mem_req,
    output logic              o_mem_wen,
    output logic [ADDR_W-3:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic [3:0]        o_mem_mask,
    input  logic              i_mem_ready,
    input  logic              i_mem_rvalid,
    input  logic [31:0]       i_mem_rdata
);

    state_t             r_state;
    logic               r_is_load;
    logic [2:0]         r_func3;
    logic [1:0]         r_off;
    logic               r_mem_req;
    logic               r_mem_wen;
    logic [ADDR_W-3:0]  r_mem_addr;
    logic [31:0]        r_mem_wdata;
    logic [3:0]         r_mem_mask;
    logic [31:0]        r_rdata;
    logic               r_rdata_valid;

    logic [1:0]         w_size;
    logic [1:0]         w_off_fix;
    logic               w_rw_ok;
    logic               w_accept;
    logic [31:0]        w_st_wdata;
    logic [3:0]         w_st_mask;
    logic [31:0]        w_ld_data;

    assign w_size  = f3_size(i_func3);
    // Exactly one of read/write; both high is a no-op.
    assign w_rw_ok = i_mem_read ^ i_mem_write;

    // Byte offset with the low bits the size cannot use forced to zero.
    // For an aligned access this equals i_addr[1:0].
    always_comb begin
        case (w_size)
            SZ_W:    w_off_fix = 2'b00;
            SZ_H:    w_off_fix = {i_addr[1], 1'b0};
            default: w_off_fix = i_addr[1:0];
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic w_aligned;
    logic w_trap;
    logic r_misaligned;

    assign w_aligned = (w_off_fix == i_addr[1:0]);
    assign w_accept  = i_rst_n & (r_state == IDLE) & i_req_valid & w_rw_ok & w_aligned;
    assign w_trap    = i_rst_n & (r_state == IDLE) & i_req_valid & w_rw_ok & ~w_aligned;
    assign o_misaligned = r_misaligned;
`else
    assign w_accept  = i_rst_n & (r_state == IDLE) & i_req_valid & w_rw_ok;
    assign o_misaligned = 1'b0;
`endif

    dmem_lane_align u_lane_align (
        .i_st_size  (w_size),
        .i_st_off   (w_off_fix),
        .i_st_data  (i_wdata),
        .o_st_wdata (w_st_wdata),
        .o_st_mask  (w_st_mask),
        .i_ld_func3 (r_func3),
        .i_ld_off   (r_off),
        .i_ld_word  (i_mem_rdata),
        .o_ld_data  (w_ld_data)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_is_load     <= 1'b0;
            r_func3       <= 3'b000;
            r_off         <= 2'b00;
            r_mem_req     <= 1'b0;
            r_mem_wen     <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= 32'h0;
            r_mem_mask    <= 4'h0;
            r_rdata       <= 32'h0;
            r_rdata_valid <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
            r_misaligned  <= 1'b0;
`endif
        end else begin
            r_rdata_valid <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
            r_misaligned  <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    // Late read responses landing here are simply ignored.
                    if (w_accept) begin
                        r_state     <= REQ;
                        r_is_load   <= i_mem_read;
                        r_func3     <= i_func3;
                        r_off       <= w_off_fix;
                        r_mem_req   <= 1'b1;
                        r_mem_wen   <= i_mem_write;
                        r_mem_addr  <= i_addr[ADDR_W-1:2];
                        r_mem_wdata <= w_st_wdata;
                        r_mem_mask  <= w_st_mask;
                    end
`ifdef DMEM_MISALIGN_TRAP_EN
                    else if (w_trap) begin
                        r_misaligned <= 1'b1;
                    end
`endif
                end
                REQ: begin
                    // Request fields stay frozen until the memory takes them.
                    if (i_mem_ready) begin
                        r_mem_req <= 1'b0;
                        r_mem_wen <= 1'b0;
                        r_state   <= r_is_load ? WAIT : DONE;
                    end
                end
                WAIT: begin
                    if (i_mem_rvalid) begin
                        r_rdata       <= w_ld_data;
                        r_rdata_valid <= 1'b1;
                        r_state       <= DONE;
                    end
                end
                DONE: begin
                    // The pipeline advances on this edge; the request still
                    // on the inputs belongs to this access, so never re-accept.
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_stall       = (r_state == REQ) | (r_state == WAIT) | w_accept;
    assign o_rdata       = r_rdata;
    assign o_rdata_valid = r_rdata_valid;
    assign o_mem_req     = r_mem_req;
    assign o_mem_wen     = r_mem_wen;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_mem_mask    = r_mem_mask;

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_ctrl
// Description : Self-checking bench for dmem_ctrl. A table of load/store
//               records with hand-computed expectations is played through
//               a transaction task; hand-written sequences cover no-op,
//               idle, misaligned-trap and reset-during-WAIT cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        misaligned;
    logic        mem_req;
    logic        mem_wen;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_mask;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    dmem_ctrl #(.ADDR_W(32)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req_valid   (req_valid),
        .i_mem_read    (mem_read),
        .i_mem_write   (mem_write),
        .i_func3       (func3),
        .i_addr        (addr),
        .i_wdata       (wdata),
        .o_stall       (stall),
        .o_rdata       (rdata),
        .o_rdata_valid (rdata_valid),
        .o_misaligned  (misaligned),
        .o_mem_req     (mem_req),
        .o_mem_wen     (mem_wen),
        .o_mem_addr    (mem_addr),
        .o_mem_wdata   (mem_wdata),
        .o_mem_mask    (mem_mask),
        .i_mem_ready   (mem_ready),
        .i_mem_rvalid  (mem_rvalid),
        .i_mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  f3;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrdata;
        logic [3:0]  emask;
        logic [31:0] ewdata;
        logic [29:0] eaddr;
        logic [31:0] erdata;
        int          rdy;
        int          rv;
    } vec_t;

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam int NTAB = 9;
`else
    localparam int NTAB = 11;
`endif
    vec_t vt[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        @(posedge clk); #1;
        req_valid = 1'b1; mem_read = v.rd; mem_write = v.wr;
        func3 = v.f3; addr = v.addr; wdata = v.wdata;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        #1;
        chk("idle_stall", {31'b0, stall}, 32'd1);
        chk("idle_req", {31'b0, mem_req}, 32'd0);
        for (int k = 0; k <= v.rdy; k++) begin
            @(posedge clk); #1;
            chk("req_valid", {31'b0, mem_req}, 32'd1);
            chk("req_stall", {31'b0, stall}, 32'd1);
            chk("req_addr", {2'b0, mem_addr}, {2'b0, v.eaddr});
            chk("req_wen", {31'b0, mem_wen}, {31'b0, v.wr});
            if (v.wr) begin
                chk("req_mask", {28'b0, mem_mask}, {28'b0, v.emask});
                chk("req_wdata", mem_wdata, v.ewdata);
            end
            mem_ready = (k == v.rdy);
        end
        @(posedge clk); #1;
        mem_ready = 1'b0;
        if (v.rd) begin
            for (int k = 0; k <= v.rv; k++) begin
                chk("wait_stall", {31'b0, stall}, 32'd1);
                chk("wait_req", {31'b0, mem_req}, 32'd0);
                chk("wait_rvld", {31'b0, rdata_valid}, 32'd0);
                if (k == v.rv) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = v.mrdata;
                end
                @(posedge clk); #1;
                mem_rvalid = 1'b0;
                mem_rdata  = 32'h0;
            end
        end
        chk("done_stall", {31'b0, stall}, 32'd0);
        chk("done_rvld", {31'b0, rdata_valid}, {31'b0, v.rd});
        chk("done_req", {31'b0, mem_req}, 32'd0);
        chk("done_mis", {31'b0, misaligned}, 32'd0);
        if (v.rd)
            chk("done_rdata", rdata, v.erdata);
        @(posedge clk); #1;
        req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        #1;
        chk("after_stall", {31'b0, stall}, 32'd0);
        chk("after_rvld", {31'b0, rdata_valid}, 32'd0);
        chk("after_req", {31'b0, mem_req}, 32'd0);
    endtask

    initial begin
        logic [31:0] last_ld;
        last_ld = 32'h0;
        //        f3      rd    wr    addr      wdata         mrdata        mask    ewdata        eaddr   erdata        rdy rv
        vt[0]  = '{3'b010, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 32'h0,        4'b1111, 32'hDEADBEEF, 30'h40, 32'h0,        0, 0};
        vt[1]  = '{3'b000, 1'b1, 1'b0, 32'h103, 32'h0,        32'h80FF0000, 4'b0000, 32'h0,        30'h40, 32'hFFFFFF80, 0, 1};
        vt[2]  = '{3'b101, 1'b1, 1'b0, 32'h102, 32'h0,        32'hBEEF1234, 4'b0000, 32'h0,        30'h40, 32'h0000BEEF, 0, 0};
        vt[3]  = '{3'b001, 1'b0, 1'b1, 32'h102, 32'h0000ABCD, 32'h0,        4'b1100, 32'hABCDABCD, 30'h40, 32'h0,        0, 0};
        vt[4]  = '{3'b000, 1'b0, 1'b1, 32'h101, 32'h12345678, 32'h0,        4'b0010, 32'h78787878, 30'h40, 32'h0,        5, 0};
        vt[5]  = '{3'b001, 1'b1, 1'b0, 32'h100, 32'h0,        32'h00008001, 4'b0000, 32'h0,        30'h40, 32'hFFFF8001, 2, 0};
        vt[6]  = '{3'b100, 1'b1, 1'b0, 32'h101, 32'h0,        32'h00009A00, 4'b0000, 32'h0,        30'h40, 32'h0000009A, 0, 0};
        vt[7]  = '{3'b010, 1'b1, 1'b0, 32'h204, 32'h0,        32'hCAFEF00D, 4'b0000, 32'h0,        30'h81, 32'hCAFEF00D, 1, 2};
        vt[8]  = '{3'b000, 1'b1, 1'b0, 32'h100, 32'h0,        32'h0000007F, 4'b0000, 32'h0,        30'h40, 32'h0000007F, 0, 3};
        // Misaligned accesses, force-aligned in the default build.
        vt[9]  = '{3'b010, 1'b1, 1'b0, 32'h101, 32'h0,        32'h11223344, 4'b0000, 32'h0,        30'h40, 32'h11223344, 0, 0};
        vt[10] = '{3'b001, 1'b0, 1'b1, 32'h103, 32'h00005A5A, 32'h0,        4'b1100, 32'h5A5A5A5A, 30'h40, 32'h0,        0, 0};

        rst_n = 1'b0; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        func3 = 3'b000; addr = 32'h0; wdata = 32'h0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_rvld", {31'b0, rdata_valid}, 32'd0);
        chk("rst_mask", {28'b0, mem_mask}, 32'd0);
        chk("rst_mis", {31'b0, misaligned}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NTAB; i++) begin
            run_vec(vt[i]);
            if (vt[i].rd)
                last_ld = vt[i].erdata;
        end

        // Read and write together: no-op, no stall, no access.
        @(posedge clk); #1;
        req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b1; func3 = 3'b010; addr = 32'h300;
        #1;
        chk("noop_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        chk("noop_req", {31'b0, mem_req}, 32'd0);
        chk("noop_stall2", {31'b0, stall}, 32'd0);
        chk("rdata_hold", rdata, last_ld);

        // Valid low: nothing happens.
        mem_write = 1'b0; req_valid = 1'b0;
        #1;
        chk("nv_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        chk("nv_req", {31'b0, mem_req}, 32'd0);

`ifdef DMEM_MISALIGN_TRAP_EN
        // Misaligned LW is trapped: one-cycle flag, no access, no stall.
        req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; func3 = 3'b010; addr = 32'h101;
        #1;
        chk("trap_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0; mem_read = 1'b0;
        chk("trap_mis", {31'b0, misaligned}, 32'd1);
        chk("trap_req", {31'b0, mem_req}, 32'd0);
        @(posedge clk); #1;
        chk("trap_mis_end", {31'b0, misaligned}, 32'd0);
        chk("trap_req2", {31'b0, mem_req}, 32'd0);
`endif

        // Reset while waiting for read data; the late response is ignored.
        @(posedge clk); #1;
        req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; func3 = 3'b010; addr = 32'h010;
        @(posedge clk); #1;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        chk("mr_wait_stall", {31'b0, stall}, 32'd1);
        rst_n = 1'b0; req_valid = 1'b0; mem_read = 1'b0;
        @(posedge clk); #1;
        chk("mr_stall", {31'b0, stall}, 32'd0);
        chk("mr_req", {31'b0, mem_req}, 32'd0);
        chk("mr_wen", {31'b0, mem_wen}, 32'd0);
        chk("mr_addr", {2'b0, mem_addr}, 32'd0);
        chk("mr_wdata", mem_wdata, 32'h0);
        chk("mr_mask", {28'b0, mem_mask}, 32'd0);
        chk("mr_rdata", rdata, 32'h0);
        chk("mr_rvld", {31'b0, rdata_valid}, 32'd0);
        rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h55555555;
        @(posedge clk); #1;
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        chk("late_rvld", {31'b0, rdata_valid}, 32'd0);
        chk("late_rdata", rdata, 32'h0);
        chk("late_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        chk("late_rvld2", {31'b0, rdata_valid}, 32'd0);
        chk("late_req", {31'b0, mem_req}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
